// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing the single-ported data memory between the MEM stage (port 0)
// and the loader/debug requester (port 1), with a starvation guard and bounded port-1 lock.
module data_mem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 20,
    parameter int MEM_SIZE      = 1024,
    parameter int STARVE_LIMIT  = 4,
    parameter int LOCK_MAX      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    input  logic                     p0_we,
    input  logic                     p0_be,
    output logic                     p0_rvalid,
    output logic [DATA_WIDTH-1:0]    p0_rdata,
    output logic                     p0_err,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    input  logic                     p1_we,
    input  logic                     p1_be,
    output logic                     p1_rvalid,
    output logic [DATA_WIDTH-1:0]    p1_rdata,
    output logic                     p1_err,
    input  logic                     p1_lock,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic                     mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    localparam logic [3:0]             STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0]             LOCK_TOP   = 8'(LOCK_MAX);
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

    state_t     state;
    logic [3:0] starve_cnt;
    logic [7:0] lock_cnt;
    logic       force_p0;
    logic       grant0;
    logic       grant1;
    logic       in_range0;
    logic       in_range1;
    logic       lock_full;

    function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
        return ({1'b0, a} < ADDR_LIMIT);
    endfunction

    assign in_range0 = addr_ok(p0_addr);
    assign in_range1 = addr_ok(p1_addr);
    assign p0_ready  = grant0;
    assign p1_ready  = grant1;
    assign lock_full = ((lock_cnt + 8'd1) == LOCK_TOP);

    // Grant selection; force_p0 overrides the starvation guard once after a forced lock exit.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (p0_valid && p1_valid) begin
                        if (!force_p0 && (starve_cnt == STARVE_MAX)) begin
                            grant1 = 1'b1;
                        end else begin
                            grant0 = 1'b1;
                        end
                    end else begin
                        grant0 = p0_valid;
                        grant1 = p1_valid;
                    end
                end
                LOCK1: begin
                    grant1 = p1_valid;
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    // Memory pins follow the granted request; out-of-range or idle cycles strobe nothing.
    always_comb begin
        mem_address    = {ADDRESS_WIDTH{1'b0}};
        mem_write_data = {DATA_WIDTH{1'b0}};
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_be         = 1'b0;
        if (grant1) begin
            mem_write_data = p1_wdata;
            mem_be         = p1_be;
            if (in_range1) begin
                mem_address = p1_addr;
                mem_we      = p1_we;
                mem_re      = !p1_we;
            end else begin
                mem_address = {ADDRESS_WIDTH{1'b0}};
            end
        end else if (grant0) begin
            mem_write_data = p0_wdata;
            mem_be         = p0_be;
            if (in_range0) begin
                mem_address = p0_addr;
                mem_we      = p0_we;
                mem_re      = !p0_we;
            end else begin
                mem_address = {ADDRESS_WIDTH{1'b0}};
            end
        end else begin
            mem_address = {ADDRESS_WIDTH{1'b0}};
        end
    end

    // Arbitration state, starvation counter and lock beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= 4'd0;
            lock_cnt   <= 8'd0;
            force_p0   <= 1'b0;
        end else begin
            if (grant1) begin
                starve_cnt <= 4'd0;
            end else if (p1_valid && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            case (state)
                ARB: begin
                    if (p0_valid && p1_valid) begin
                        force_p0 <= 1'b0;
                    end
                    if (grant1 && p1_lock) begin
                        // A one-beat lock is exhausted by its own entry beat.
                        if (LOCK_TOP == 8'd1) begin
                            force_p0 <= 1'b1;
                        end else begin
                            state    <= LOCK1;
                            lock_cnt <= 8'd1;
                        end
                    end
                end
                LOCK1: begin
                    if (grant1) begin
                        if (!p1_lock || lock_full) begin
                            state    <= ARB;
                            lock_cnt <= 8'd0;
                            force_p0 <= lock_full;
                        end else begin
                            lock_cnt <= lock_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

    // Registered responses; out-of-range reads return zero alongside the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= {DATA_WIDTH{1'b0}};
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= {DATA_WIDTH{1'b0}};
        end else begin
            p0_rvalid <= grant0 && !p0_we;
            p0_err    <= grant0 && !in_range0;
            p1_rvalid <= grant1 && !p1_we;
            p1_err    <= grant1 && !in_range1;
            if (grant0 && !p0_we) begin
                p0_rdata <= in_range0 ? mem_read_data : {DATA_WIDTH{1'b0}};
            end
            if (grant1 && !p1_we) begin
                p1_rdata <= in_range1 ? mem_read_data : {DATA_WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a spec-level model predicts grants, memory strobes
// and responses; a monitor compares them against the DUT each cycle.
module tb_data_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 20;
    localparam int MSZ = 1024;
    localparam int SL  = 4;
    localparam int LM  = 8;

    typedef struct packed {
        logic          v;
        logic          we;
        logic          be;
        logic          lk;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct packed {
        logic          r0;
        logic          r1;
        logic          gnt;
        logic          we;
        logic          re;
        logic          be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } cyc_t;

    typedef struct packed {
        int            due;
        logic          rv;
        logic          err;
        logic [DW-1:0] rd;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p0_valid = 1'b0, p0_ready, p0_we = 1'b0, p0_be = 1'b0, p0_rvalid, p0_err;
    logic p1_valid = 1'b0, p1_ready, p1_we = 1'b0, p1_be = 1'b0, p1_rvalid, p1_err, p1_lock = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0, mem_address;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0, p0_rdata, p1_rdata, mem_write_data, mem_read_data;
    logic mem_we, mem_re, mem_be;

    data_mem_arbiter #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MSZ), .STARVE_LIMIT(SL), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_we(p0_we), .p0_be(p0_be), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_we(p1_we), .p1_be(p1_be), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .p1_lock(p1_lock),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_we(mem_we),
        .mem_re(mem_re), .mem_be(mem_be), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    cyc_t  cyc_q[$];
    resp_t rq0[$];
    resp_t rq1[$];

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16:      return 8'hEF;
            17:      return 8'hBE;
            18:      return 8'hAD;
            19:      return 8'hDE;
            default: return 8'((i * 37 + 11) ^ (i >> 3));
        endcase
    endfunction

    // Memory the DUT drives: byte array, little-endian words, combinational read.
    logic [7:0] env_mem [0:MSZ-1];
    logic       mem_loaded = 1'b0;
    int         rd_idx;
    always_comb begin
        rd_idx = int'(mem_address) % MSZ;
        if (mem_be) mem_read_data = {24'h0, env_mem[rd_idx]};
        else mem_read_data = {env_mem[(rd_idx + 3) % MSZ], env_mem[(rd_idx + 2) % MSZ],
                              env_mem[(rd_idx + 1) % MSZ], env_mem[rd_idx]};
    end
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MSZ; i++) env_mem[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            if (mem_be) env_mem[int'(mem_address) % MSZ] <= mem_write_data[7:0];
            else for (int k = 0; k < 4; k++)
                env_mem[(int'(mem_address) + k) % MSZ] <= mem_write_data[8*k +: 8];
        end
    end

    // Reference model state: spec rules in plain integers
    logic [7:0] shadow [0:MSZ-1];
    bit m_lock = 0, m_force = 0, m_g0, m_g1;
    int m_beats = 0, m_starve = 0;

    function automatic logic [DW-1:0] shadow_read(input int a, input logic be);
        if (be) return {24'h0, shadow[a % MSZ]};
        return {shadow[(a + 3) % MSZ], shadow[(a + 2) % MSZ], shadow[(a + 1) % MSZ], shadow[a % MSZ]};
    endfunction

    task automatic step(input logic r, input req_t q0, input req_t q1);
        cyc_t c;
        resp_t e;
        req_t s;
        bit g0, g1, ok;
        @(posedge clk);
        #1;
        rst = r;
        p0_valid = q0.v; p0_addr = q0.a; p0_wdata = q0.d; p0_we = q0.we; p0_be = q0.be;
        p1_valid = q1.v; p1_addr = q1.a; p1_wdata = q1.d; p1_we = q1.we; p1_be = q1.be;
        p1_lock = q1.lk;
        g0 = 0; g1 = 0;
        if (r) begin
            m_lock = 0; m_beats = 0; m_starve = 0; m_force = 0;
        end else begin
            if (m_lock) begin
                g1 = q1.v;
                if (g1) begin
                    m_beats++;
                    if (!q1.lk || m_beats == LM) begin
                        m_force = (m_beats == LM);
                        m_lock = 0;
                        m_beats = 0;
                    end
                end
            end else begin
                if (q0.v && q1.v) begin
                    g1 = !m_force && (m_starve == SL);
                    g0 = !g1;
                    m_force = 0;
                end else begin
                    g0 = q0.v;
                    g1 = q1.v;
                end
                if (g1 && q1.lk) begin
                    if (LM == 1) m_force = 1;
                    else begin m_lock = 1; m_beats = 1; end
                end
            end
            if (g1) m_starve = 0;
            else if (q1.v && m_starve < SL) m_starve++;
        end
        m_g0 = g0; m_g1 = g1;
        s = g1 ? q1 : q0;
        ok = (int'(s.a) < MSZ);
        c.r0 = g0; c.r1 = g1; c.gnt = g0 | g1;
        c.we = c.gnt && ok && s.we;
        c.re = c.gnt && ok && !s.we;
        c.addr = (c.gnt && ok) ? s.a : '0;
        c.be = s.be; c.wd = s.d;
        cyc_q.push_back(c);
        if (c.gnt) begin
            if (!ok || !s.we) begin
                e.due = cyc + 1; e.rv = !s.we; e.err = !ok;
                e.rd = ok ? shadow_read(int'(s.a), s.be) : '0;
                if (g0) rq0.push_back(e); else rq1.push_back(e);
            end else if (s.be) shadow[int'(s.a)] = s.d[7:0];
            else for (int k = 0; k < 4; k++) shadow[(int'(s.a) + k) % MSZ] = s.d[8*k +: 8];
        end
    endtask

    function automatic req_t mk(input logic we, input logic be, input logic lk, input int a, input logic [DW-1:0] d);
        req_t q;
        q.v = 1'b1; q.we = we; q.be = be; q.lk = lk; q.a = AW'(a); q.d = d;
        return q;
    endfunction

    function automatic req_t rnd_req(input bit allow_lock);
        req_t q;
        q.v = 1'b1; q.we = 1'($urandom_range(0, 1)); q.be = 1'($urandom_range(0, 1));
        q.d = $urandom; q.lk = allow_lock && ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 9))
            0:       q.a = AW'(MSZ + $urandom_range(0, 1) * $urandom_range(0, 200));
            1:       q.a = AW'(MSZ - 1 - $urandom_range(0, 3));
            default: q.a = AW'($urandom_range(0, MSZ - 1));
        endcase
        return q;
    endfunction

    task automatic chk_port(input int p, input logic rv, input logic err, input logic [DW-1:0] rd);
        resp_t e;
        bit have;
        have = (p == 0) ? (rq0.size() > 0 && rq0[0].due == cyc) : (rq1.size() > 0 && rq1[0].due == cyc);
        nvec++;
        if (have) begin
            if (p == 0) e = rq0.pop_front(); else e = rq1.pop_front();
            if (rv !== e.rv || err !== e.err || (e.rv && rd !== e.rd)) begin
                nerr++;
                $display("FAIL resp_p%0d cyc=%0d got rvalid=%b err=%b rdata=%h want rvalid=%b err=%b rdata=%h",
                         p, cyc, rv, err, rd, e.rv, e.err, e.rd);
            end
        end else if (rv !== 1'b0 || err !== 1'b0) begin
            nerr++;
            $display("FAIL resp_p%0d_spurious cyc=%0d got rvalid=%b err=%b want 0 0", p, cyc, rv, err);
        end
    endtask

    // Monitor: compares combinational grant/strobe outputs and registered responses every cycle.
    initial begin
        cyc_t c;
        @(posedge clk);
        forever begin
            @(negedge clk);
            nvec++;
            if (cyc_q.size() == 0) begin
                nerr++;
                $display("FAIL cyc_queue cyc=%0d got no expectation want one", cyc);
            end else begin
                c = cyc_q.pop_front();
                if ({p0_ready, p1_ready, mem_we, mem_re, mem_address} !== {c.r0, c.r1, c.we, c.re, c.addr}) begin
                    nerr++;
                    $display("FAIL grant cyc=%0d got rdy0=%b rdy1=%b we=%b re=%b addr=%h want %b %b %b %b %h",
                             cyc, p0_ready, p1_ready, mem_we, mem_re, mem_address, c.r0, c.r1, c.we, c.re, c.addr);
                end
                if (c.gnt) begin
                    nvec++;
                    if ({mem_be, mem_write_data} !== {c.be, c.wd}) begin
                        nerr++;
                        $display("FAIL mem_data cyc=%0d got be=%b wdata=%h want be=%b wdata=%h",
                                 cyc, mem_be, mem_write_data, c.be, c.wd);
                    end
                end
            end
            chk_port(0, p0_rvalid, p0_err, p0_rdata);
            chk_port(1, p1_rvalid, p1_err, p1_rdata);
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        req_t idle, q0, q1;
        bit pend0, pend1;
        int n1;
        idle = '0;
        for (int i = 0; i < MSZ; i++) shadow[i] = init_byte(i);

        for (int i = 0; i < 3; i++) step(1'b1, mk(1'b0, 1'b0, 1'b0, 16, '0), mk(1'b0, 1'b0, 1'b1, 4, '0));
        step(1'b0, mk(1'b0, 1'b0, 1'b0, 16'h10, '0), idle);
        step(1'b0, idle, idle);

        for (int i = 0; i < 12; i++) step(1'b0, mk(1'b0, 1'b0, 1'b0, 64, '0), mk(1'b0, 1'b0, 1'b0, 128, '0));
        step(1'b0, idle, idle);

        n1 = 0;
        for (int i = 0; i < 60 && n1 < 10; i++) begin
            step(1'b0, mk(1'b0, 1'b0, 1'b0, 200, '0), mk(1'b0, 1'b0, 1'b1, 300 + n1 * 4, '0));
            if (m_g1) n1++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, mk(1'b0, 1'b0, 1'b0, 200, '0), idle);

        step(1'b0, mk(1'b1, 1'b1, 1'b0, 16'h21, 32'h0000_00AB), idle);
        step(1'b0, idle, mk(1'b0, 1'b1, 1'b0, 16'h21, '0));
        step(1'b0, idle, mk(1'b0, 1'b0, 1'b0, MSZ, '0));
        step(1'b0, idle, mk(1'b1, 1'b0, 1'b0, MSZ + 5, 32'h1234_5678));
        step(1'b0, idle, idle);

        step(1'b0, idle, mk(1'b0, 1'b0, 1'b1, 400, '0));
        step(1'b0, idle, mk(1'b0, 1'b0, 1'b1, 404, '0));
        step(1'b1, idle, mk(1'b0, 1'b0, 1'b1, 408, '0));
        step(1'b0, mk(1'b0, 1'b0, 1'b0, 16'h10, '0), idle);
        step(1'b0, idle, idle);

        pend0 = 0; pend1 = 0; q0 = idle; q1 = idle;
        for (int i = 0; i < 2500; i++) begin
            if (!pend0) begin
                if ($urandom_range(0, 9) < 6) begin q0 = rnd_req(1'b0); pend0 = 1; end
                else q0 = idle;
            end
            if (!pend1) begin
                if ($urandom_range(0, 9) < 7) begin q1 = rnd_req(1'b1); pend1 = 1; end
                else q1 = idle;
            end
            step(($urandom_range(0, 299) == 0), q0, q1);
            if (m_g0) pend0 = 0;
            if (m_g1) pend1 = 0;
        end
        for (int i = 0; i < 3; i++) step(1'b0, idle, idle);

        @(negedge clk);
        #2;
        nvec++;
        if (cyc_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
            nerr++;
            $display("FAIL leftover got cyc=%0d rq0=%0d rq1=%0d want 0 0 0", cyc_q.size(), rq0.size(), rq1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
